// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit indices and FSM state type.
// The processor core imports the same names, so they are defined only here.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] ADD  = 3'b000;
  localparam logic [OP_W-1:0] SUB  = 3'b001;
  localparam logic [OP_W-1:0] AND  = 3'b010;
  localparam logic [OP_W-1:0] OR   = 3'b011;
  localparam logic [OP_W-1:0] EOR  = 3'b100;
  localparam logic [OP_W-1:0] SL   = 3'b101;
  localparam logic [OP_W-1:0] SR   = 3'b110;
  localparam logic [OP_W-1:0] PASS = 3'b111;

  localparam int unsigned CARRY    = 0;
  localparam int unsigned ZERO     = 1;
  localparam int unsigned OVERFLOW = 6;
  localparam int unsigned SIGN     = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    BCD_HI = 1'b1
  } state_t;

endpackage

// File: rtl/alu_bcd_nibble.sv
// One decimal digit of a BCD add/subtract: binary nibble sum with carry-in,
// then the decimal adjust (+6 above nine for ADD, -6 on borrow for SUB).
module alu_bcd_nibble
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [NIB_W-1:0] y_c,
  output logic             cout_c
);

  localparam int unsigned SUM_W = NIB_W + 1;

  logic [NIB_W-1:0] b_eff;
  logic [SUM_W-1:0] sum;

  always_comb begin
    b_eff  = sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + SUM_W'(cin);
    y_c    = sum[NIB_W-1:0];
    cout_c = sum[NIB_W];
    if (sub) begin
      // Carry out of the nibble means no borrow; a borrow needs -6 correction.
      if (!sum[NIB_W]) begin
        y_c = sum[NIB_W-1:0] - NIB_W'(6);
      end
    end else if (sum > SUM_W'(9)) begin
      y_c    = sum[NIB_W-1:0] + NIB_W'(6);
      cout_c = 1'b1;
    end
  end

endmodule

// File: rtl/alu.sv
// 8-bit ALU with 6502-style flags. Binary ops finish in one cycle; decimal
// ADD/SUB run low nibble then high nibble through a shared nibble adjuster.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_AI,
  input  logic [DATA_W-1:0] alu_BI,
  input  logic              alu_carry,
  input  logic              alu_BCD,
  output logic [DATA_W-1:0] alu_Y,
  output logic [DATA_W-1:0] alu_flags,
  output logic              alu_done,
  output logic              alu_busy
);

  localparam int unsigned SUM_W = DATA_W + 1;

  state_t              state, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                carry_q, carry_d;
  logic                sub_q, sub_d;
  logic [NIB_W-1:0]    lo_q, lo_d;
  logic                hc_q, hc_d;
  logic [DATA_W-1:0]   y_d, flags_d;
  logic                done_d, busy_d;

  logic [DATA_W-1:0]   op_a, op_b, bin_b, res;
  logic                op_c, op_sub, bin_v;
  logic [SUM_W-1:0]    bin_sum;
  logic [NIB_W-1:0]    nib_a, nib_b, nib_y;
  logic                nib_cin, nib_cout;

  // Operand source: live inputs when idle, latched copy for the high nibble.
  always_comb begin
    op_a    = (state == BCD_HI) ? a_q     : alu_AI;
    op_b    = (state == BCD_HI) ? b_q     : alu_BI;
    op_c    = (state == BCD_HI) ? carry_q : alu_carry;
    op_sub  = (state == BCD_HI) ? sub_q   : (alu_ctrl == SUB);
    bin_b   = op_sub ? ~op_b : op_b;
    bin_sum = {1'b0, op_a} + {1'b0, bin_b} + SUM_W'(op_c);
    bin_v   = (op_a[DATA_W-1] ^ bin_sum[DATA_W-1]) & (bin_b[DATA_W-1] ^ bin_sum[DATA_W-1]);
    nib_a   = (state == BCD_HI) ? a_q[DATA_W-1:NIB_W] : alu_AI[NIB_W-1:0];
    nib_b   = (state == BCD_HI) ? b_q[DATA_W-1:NIB_W] : alu_BI[NIB_W-1:0];
    nib_cin = (state == BCD_HI) ? hc_q : alu_carry;
  end

  alu_bcd_nibble u_nibble (
    .a      (nib_a),
    .b      (nib_b),
    .cin    (nib_cin),
    .sub    (op_sub),
    .y_c    (nib_y),
    .cout_c (nib_cout)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    lo_d    = lo_q;
    hc_d    = hc_q;
    y_d     = alu_Y;
    flags_d = alu_flags;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    res     = alu_Y;

    case (state)
      IDLE: begin
        if (alu_valid) begin
          if (alu_BCD && (alu_ctrl == ADD || alu_ctrl == SUB)) begin
            a_d     = alu_AI;
            b_d     = alu_BI;
            carry_d = alu_carry;
            sub_d   = (alu_ctrl == SUB);
            lo_d    = nib_y;
            hc_d    = nib_cout;
            busy_d  = 1'b1;
            state_d = BCD_HI;
          end else begin
            done_d = 1'b1;
            case (alu_ctrl)
              ADD, SUB: begin
                res                = bin_sum[DATA_W-1:0];
                flags_d[CARRY]     = bin_sum[DATA_W];
                flags_d[OVERFLOW]  = bin_v;
              end
              AND: res = alu_AI & alu_BI;
              OR:  res = alu_AI | alu_BI;
              EOR: res = alu_AI ^ alu_BI;
              SL: begin
                res            = {alu_AI[DATA_W-2:0], alu_carry};
                flags_d[CARRY] = alu_AI[DATA_W-1];
              end
              SR: begin
                res            = {alu_carry, alu_AI[DATA_W-1:1]};
                flags_d[CARRY] = alu_AI[0];
              end
              default: res = alu_AI;
            endcase
          end
        end
      end
      BCD_HI: begin
        // V still reflects the binary sum of the latched operands.
        res               = {nib_y, lo_q};
        flags_d[CARRY]    = nib_cout;
        flags_d[OVERFLOW] = bin_v;
        done_d            = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done_d) begin
      y_d           = res;
      flags_d[SIGN] = res[DATA_W-1];
      flags_d[ZERO] = (res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      lo_q      <= '0;
      hc_q      <= 1'b0;
      alu_Y     <= '0;
      alu_flags <= '0;
      alu_done  <= 1'b0;
      alu_busy  <= 1'b0;
    end else begin
      state     <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      sub_q     <= sub_d;
      lo_q      <= lo_d;
      hc_q      <= hc_d;
      alu_Y     <= y_d;
      alu_flags <= flags_d;
      alu_done  <= done_d;
      alu_busy  <= busy_d;
    end
  end

endmodule
